// File: rtl/midi_msg_parser_if.sv
// MIDI parser bus: received-byte input side and decoded-message output side.
//   RX_DATA/RX_VALID       : byte stream from the UART receiver
//   MSG_VALID + fields     : decoded channel message strobe
//   RT_VALID/RT_BYTE       : real-time byte passthrough
//   ERR                    : timeout / aborted-message strobe
// master = byte source and message consumer, slave = the parser.
interface midi_msg_parser_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       MSG_VALID;
    logic [3:0] CH_MESSAGE;
    logic [3:0] CHAN;
    logic [6:0] DATA1;
    logic [6:0] DATA2;
    logic       RT_VALID;
    logic [7:0] RT_BYTE;
    logic       ERR;

    modport master (
        output RX_DATA, RX_VALID,
        input  MSG_VALID, CH_MESSAGE, CHAN, DATA1, DATA2, RT_VALID, RT_BYTE, ERR
    );

    modport slave (
        input  RX_DATA, RX_VALID,
        output MSG_VALID, CH_MESSAGE, CHAN, DATA1, DATA2, RT_VALID, RT_BYTE, ERR
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status, channel filtering, real-time
// passthrough, SysEx skipping and an inter-byte timeout.
// Ports:
//   CLK : system clock
//   RES : synchronous active-high reset
//   bus : midi_msg_parser_if.slave (byte input, message/RT/ERR outputs)
// All outputs are registered; strobes appear one cycle after the byte.
module midi_msg_parser #(
    parameter logic [15:0] CHAN_MASK      = 16'hFFFF,
    parameter bit          RUNNING_STATUS = 1'b1,
    parameter bit          VEL0_IS_OFF    = 1'b1,
    parameter logic [23:0] TIMEOUT        = 24'd500000
) (
    input  logic                  CLK,
    input  logic                  RES,
    midi_msg_parser_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [7:0]  rs_r, rs_next_s;
    logic        rs_valid_r, rs_valid_next_s;
    logic [6:0]  d1_r, d1_next_s;
    logic [23:0] cnt_r, cnt_next_s;

    logic        rx_rt_s, rx_byte_s, take_d1_s;
    logic        emit_s, accept_s, err_s, rt_s;
    logic [6:0]  emit_d1_s, emit_d2_s;
    logic [3:0]  emit_cmd_s;

    // Program change (C) and channel pressure (D) carry a single data byte.
    function automatic logic one_data_byte(input logic [3:0] nib);
        return (nib == 4'hC) || (nib == 4'hD);
    endfunction

    assign rx_rt_s   = bus.RX_VALID && (bus.RX_DATA[7:3] == 5'b11111);
    assign rx_byte_s = bus.RX_VALID && !rx_rt_s;

    // Next-state, running-status, data and timeout-counter decisions.
    always_comb begin
        state_next_s    = state_r;
        rs_next_s       = rs_r;
        rs_valid_next_s = rs_valid_r;
        d1_next_s       = d1_r;
        cnt_next_s      = cnt_r;
        take_d1_s       = 1'b0;
        emit_s          = 1'b0;
        emit_d1_s       = d1_r;
        emit_d2_s       = 7'd0;
        err_s           = 1'b0;
        rt_s            = rx_rt_s;

        if (rx_byte_s) begin
            cnt_next_s = 24'd0;
            if (bus.RX_DATA[7] == 1'b0) begin
                case (state_r)
                    IDLE: begin
                        if (RUNNING_STATUS && rs_valid_r) begin
                            take_d1_s = 1'b1;
                        end else begin
                            take_d1_s = 1'b0;
                        end
                    end
                    WAIT_D1: take_d1_s = 1'b1;
                    WAIT_D2: begin
                        emit_s       = 1'b1;
                        emit_d2_s    = bus.RX_DATA[6:0];
                        state_next_s = IDLE;
                    end
                    SYSEX:   state_next_s = SYSEX;
                    default: state_next_s = IDLE;
                endcase
            end else if (bus.RX_DATA[7:4] != 4'hF) begin
                // New channel status aborts any message still being collected.
                rs_next_s       = bus.RX_DATA;
                rs_valid_next_s = 1'b1;
                state_next_s    = WAIT_D1;
                err_s           = (state_r == WAIT_D1) || (state_r == WAIT_D2);
            end else if (bus.RX_DATA[3:0] == 4'h0) begin
                rs_valid_next_s = 1'b0;
                state_next_s    = SYSEX;
            end else begin
                rs_valid_next_s = 1'b0;
                state_next_s    = IDLE;
            end
        end else if ((state_r == WAIT_D1) || (state_r == WAIT_D2)) begin
            // Real-time bytes do not restart the inter-byte timer.
            if ((TIMEOUT != 24'd0) && (cnt_r == TIMEOUT)) begin
                state_next_s = IDLE;
                err_s        = 1'b1;
                cnt_next_s   = 24'd0;
            end else if (cnt_r != 24'hFFFFFF) begin
                cnt_next_s = cnt_r + 24'd1;
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cnt_next_s = 24'd0;
        end

        if (take_d1_s) begin
            d1_next_s = bus.RX_DATA[6:0];
            if (one_data_byte(rs_r[7:4])) begin
                emit_s       = 1'b1;
                emit_d1_s    = bus.RX_DATA[6:0];
                state_next_s = IDLE;
            end else begin
                state_next_s = WAIT_D2;
            end
        end else begin
            d1_next_s = d1_next_s;
        end

        if (VEL0_IS_OFF && (rs_r[7:4] == 4'h9) && (emit_d2_s == 7'd0)) begin
            emit_cmd_s = 4'h8;
        end else begin
            emit_cmd_s = rs_r[7:4];
        end
        accept_s = emit_s && CHAN_MASK[rs_r[3:0]];
    end

    // FSM state and parser context registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r    <= IDLE;
            rs_r       <= 8'h00;
            rs_valid_r <= 1'b0;
            d1_r       <= 7'd0;
            cnt_r      <= 24'd0;
        end else begin
            state_r    <= state_next_s;
            rs_r       <= rs_next_s;
            rs_valid_r <= rs_valid_next_s;
            d1_r       <= d1_next_s;
            cnt_r      <= cnt_next_s;
        end
    end

    // Registered outputs; message fields only change on an accepted message.
    always_ff @(posedge CLK) begin
        if (RES) begin
            bus.MSG_VALID  <= 1'b0;
            bus.CH_MESSAGE <= 4'h0;
            bus.CHAN       <= 4'h0;
            bus.DATA1      <= 7'd0;
            bus.DATA2      <= 7'd0;
            bus.RT_VALID   <= 1'b0;
            bus.RT_BYTE    <= 8'h00;
            bus.ERR        <= 1'b0;
        end else begin
            bus.MSG_VALID <= accept_s;
            if (accept_s) begin
                bus.CH_MESSAGE <= emit_cmd_s;
                bus.CHAN       <= rs_r[3:0];
                bus.DATA1      <= emit_d1_s;
                bus.DATA2      <= emit_d2_s;
            end
            bus.RT_VALID <= rt_s;
            if (rt_s) begin
                bus.RT_BYTE <= bus.RX_DATA;
            end
            bus.ERR <= err_s;
        end
    end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench for midi_msg_parser: two instances with different
// parameter sets receive the same byte stream (directed test-plan sequences,
// then random traffic) and every cycle is compared against a byte-level model.
module tb_midi_msg_parser;

    logic clk;
    logic res;
    int   total;
    int   bad;

    midi_msg_parser_if if0();
    midi_msg_parser_if if1();

    midi_msg_parser #(
        .CHAN_MASK(16'hFFFF), .RUNNING_STATUS(1'b1), .VEL0_IS_OFF(1'b1), .TIMEOUT(24'd40)
    ) dut0 (.CLK(clk), .RES(res), .bus(if0.slave));

    midi_msg_parser #(
        .CHAN_MASK(16'h0001), .RUNNING_STATUS(1'b0), .VEL0_IS_OFF(1'b0), .TIMEOUT(24'd0)
    ) dut1 (.CLK(clk), .RES(res), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Parameter sets mirrored for the model
    logic [15:0] p_mask [2];
    bit          p_rs   [2];
    bit          p_vel  [2];
    int unsigned p_to   [2];

    // Model context: running status, message in progress, data collected so far
    int unsigned m_gap   [2];
    bit          m_coll  [2];
    bit          m_sysex [2];
    bit          m_rsok  [2];
    logic [7:0]  m_rs    [2];
    int          m_cnt   [2];
    logic [6:0]  m_d1    [2];

    // Expected outputs after the coming clock edge
    bit          e_mv  [2];
    bit          e_rtv [2];
    bit          e_err [2];
    logic [3:0]  e_cmd [2];
    logic [3:0]  e_ch  [2];
    logic [6:0]  e_d1  [2];
    logic [6:0]  e_d2  [2];
    logic [7:0]  e_rtb [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_emit(input int k, input logic [6:0] a, input logic [6:0] b);
        if (p_mask[k][m_rs[k][3:0]]) begin
            e_mv[k]  = 1'b1;
            e_cmd[k] = (p_vel[k] && m_rs[k][7:4] == 4'h9 && b == 7'd0) ? 4'h8 : m_rs[k][7:4];
            e_ch[k]  = m_rs[k][3:0];
            e_d1[k]  = a;
            e_d2[k]  = b;
        end
        m_coll[k] = 1'b0;
        m_cnt[k]  = 0;
    endtask

    task automatic model_step(input int k, input bit r, input bit v, input logic [7:0] b);
        int len;
        e_mv[k]  = 1'b0;
        e_rtv[k] = 1'b0;
        e_err[k] = 1'b0;
        if (r) begin
            m_gap[k] = 0; m_coll[k] = 0; m_sysex[k] = 0; m_rsok[k] = 0;
            m_rs[k] = 8'h00; m_cnt[k] = 0; m_d1[k] = 7'd0;
            e_cmd[k] = 4'h0; e_ch[k] = 4'h0; e_d1[k] = 7'd0; e_d2[k] = 7'd0; e_rtb[k] = 8'h00;
        end else if (v && b < 8'hF8) begin
            m_gap[k] = 0;
            if (b >= 8'h80 && b < 8'hF0) begin
                if (m_coll[k]) e_err[k] = 1'b1;
                m_rs[k] = b; m_rsok[k] = 1'b1; m_coll[k] = 1'b1; m_cnt[k] = 0; m_sysex[k] = 1'b0;
            end else if (b == 8'hF0) begin
                m_rsok[k] = 1'b0; m_coll[k] = 1'b0; m_sysex[k] = 1'b1;
            end else if (b > 8'hF0) begin
                m_rsok[k] = 1'b0; m_coll[k] = 1'b0; m_sysex[k] = 1'b0;
            end else if (!m_sysex[k] && (m_coll[k] || (p_rs[k] && m_rsok[k]))) begin
                m_coll[k] = 1'b1;
                len = (m_rs[k][7:4] == 4'hC || m_rs[k][7:4] == 4'hD) ? 1 : 2;
                if (m_cnt[k] == 0) begin
                    m_d1[k]  = b[6:0];
                    m_cnt[k] = 1;
                    if (len == 1) model_emit(k, b[6:0], 7'd0);
                end else begin
                    model_emit(k, m_d1[k], b[6:0]);
                end
            end
        end else begin
            if (v) begin
                e_rtv[k] = 1'b1;
                e_rtb[k] = b;
            end
            m_gap[k]++;
            if (m_coll[k] && p_to[k] != 0 && m_gap[k] > p_to[k]) begin
                e_err[k]  = 1'b1;
                m_coll[k] = 1'b0;
                m_cnt[k]  = 0;
            end
        end
    endtask

    task automatic compare_dut(input int k, input logic mv, input logic [3:0] cmd,
                               input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2,
                               input logic rtv, input logic [7:0] rtb, input logic err);
        check_val($sformatf("dut%0d.msg_valid", k), 32'(mv), 32'(e_mv[k]));
        check_val($sformatf("dut%0d.ch_message", k), 32'(cmd), 32'(e_cmd[k]));
        check_val($sformatf("dut%0d.chan", k), 32'(ch), 32'(e_ch[k]));
        check_val($sformatf("dut%0d.data1", k), 32'(d1), 32'(e_d1[k]));
        check_val($sformatf("dut%0d.data2", k), 32'(d2), 32'(e_d2[k]));
        check_val($sformatf("dut%0d.rt_valid", k), 32'(rtv), 32'(e_rtv[k]));
        check_val($sformatf("dut%0d.rt_byte", k), 32'(rtb), 32'(e_rtb[k]));
        check_val($sformatf("dut%0d.err", k), 32'(err), 32'(e_err[k]));
    endtask

    task automatic drive_cycle(input bit r, input bit v, input logic [7:0] b);
        @(negedge clk);
        res          = r;
        if0.RX_VALID = v;
        if0.RX_DATA  = b;
        if1.RX_VALID = v;
        if1.RX_DATA  = b;
        model_step(0, r, v, b);
        model_step(1, r, v, b);
        @(posedge clk);
        #1;
        compare_dut(0, if0.MSG_VALID, if0.CH_MESSAGE, if0.CHAN, if0.DATA1, if0.DATA2,
                    if0.RT_VALID, if0.RT_BYTE, if0.ERR);
        compare_dut(1, if1.MSG_VALID, if1.CH_MESSAGE, if1.CHAN, if1.DATA1, if1.DATA2,
                    if1.RT_VALID, if1.RT_BYTE, if1.ERR);
    endtask

    task automatic send(input logic [7:0] b);
        drive_cycle(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_seq(input logic [7:0] s [$]);
        foreach (s[i]) send(s[i]);
        idle(2);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        total = 0;
        bad   = 0;
        p_mask[0] = 16'hFFFF; p_rs[0] = 1'b1; p_vel[0] = 1'b1; p_to[0] = 40;
        p_mask[1] = 16'h0001; p_rs[1] = 1'b0; p_vel[1] = 1'b0; p_to[1] = 0;
        res = 1'b1;
        if0.RX_VALID = 1'b0; if0.RX_DATA = 8'h00;
        if1.RX_VALID = 1'b0; if1.RX_DATA = 8'h00;

        drive_cycle(1'b1, 1'b0, 8'h00);
        drive_cycle(1'b1, 1'b1, 8'h90);
        idle(2);

        // Directed sequences
        send_seq('{8'h90, 8'h3C, 8'h64});
        send_seq('{8'h93, 8'h3C, 8'h64, 8'h3E, 8'h50});
        send_seq('{8'h90, 8'h3C, 8'h00});
        send_seq('{8'hC5, 8'h07});
        send_seq('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
        send_seq('{8'h91, 8'h40, 8'h40, 8'h90, 8'h40, 8'h40});
        send(8'h90); send(8'h3C);
        idle(45);
        send_seq('{8'h40, 8'h7F});
        send(8'h90); send(8'h3C);
        idle(39);
        send_seq('{8'h41});
        send(8'h92); send(8'h10);
        idle(40);
        send_seq('{8'h20});
        send_seq('{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h40});
        send_seq('{8'hB0, 8'h07, 8'hE1, 8'h00, 8'h40, 8'hD0, 8'h33, 8'h34});
        send(8'h90); send(8'h3C);
        drive_cycle(1'b1, 1'b1, 8'h64);
        send_seq('{8'h64, 8'h90, 8'h01, 8'h02});

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      idle(0);
            else if (r < 90) idle($urandom_range(1, 3));
            else if (r < 98) idle($urandom_range(30, 50));
            else             drive_cycle(1'b1, 1'($urandom_range(0, 1)), 8'h90);
            r = $urandom_range(0, 99);
            if (r < 55)      b = 8'($urandom_range(0, 127));
            else if (r < 80) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 88) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(8'hF8, 8'hFF));
            send(b);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Parametrised MIDI byte-stream parser, the successor to the fixed three-byte channel-message decoder. It consumes bytes from the MIDI UART receiver and emits one-cycle-strobed channel messages. It adds running status, correct two-byte message lengths, per-channel filtering, real-time byte passthrough, SysEx skipping and an inter-byte timeout. It sits between `uart_rx` and the voice/controller logic of the synth.

## Interface
Parameters:
- `CHAN_MASK`, 16'hFFFF: bit n = 1 accepts channel n (0-based); rejected messages are parsed but not emitted.
- `RUNNING_STATUS`, 1: 1 = reuse last channel status byte for data bytes arriving in IDLE.
- `VEL0_IS_OFF`, 1: 1 = Note On with velocity 0 is reported as Note Off (4'h8).
- `TIMEOUT`, 24'd500000: CLK cycles allowed between bytes of one message (10 ms at 50 MHz); 0 disables.

Ports:
- `CLK` in 1: system clock, 50 MHz.
- `RES` in 1: synchronous active-high reset; one clock, reset is synchronous and active-high.
- `RX_DATA` in 8: received byte; valid only when `RX_VALID`.
- `RX_VALID` in 1: one-cycle strobe per received byte.
- `MSG_VALID` out 1: one-cycle strobe; the `CH_MESSAGE`/`CHAN`/`DATA1`/`DATA2` fields are new this cycle.
- `CH_MESSAGE` out 4: status high nibble, 4'h8..4'hE.
- `CHAN` out 4: channel, 0..15.
- `DATA1` out 7: note / controller / program / pressure / pitch LSB.
- `DATA2` out 7: velocity / value / pitch MSB; 0 for two-byte messages.
- `RT_VALID` out 1: one-cycle strobe for a real-time byte (F8..FF).
- `RT_BYTE` out 8: the real-time byte.
- `ERR` out 1: one-cycle strobe on a timeout or an unexpected byte.

## Operation
- Byte classes:
  - data: bit7 = 0.
  - channel status: 8x..Ex.
  - system common: F0..F7.
  - real-time: F8..FF.
- Message length: 8,9,A,B,E have 2 data bytes; C,D have 1 data byte.
- States: IDLE, WAIT_D1, WAIT_D2, SYSEX.
- Real-time byte in any state: `RT_BYTE` <= byte, `RT_VALID` pulses. State, running status and the timeout counter are untouched.
- Channel status byte in any state:
  - Latch it as the running status (`rs_reg`, valid flag set).
  - Go to WAIT_D1.
  - If the previous state was WAIT_D1 or WAIT_D2 (message aborted), pulse `ERR`.
- F0: clear the running-status valid flag, go to SYSEX. In SYSEX, data bytes are discarded.
- F1..F7: clear the running-status valid flag, go to IDLE. Their data bytes are ignored. F7 in SYSEX ends SysEx.
- IDLE + data byte:
  - If `RUNNING_STATUS` = 1 and the flag is valid, treat the byte as the first data byte.
  - Otherwise discard it silently.
- WAIT_D1 + data byte: store it in d1.
  - Two-byte message: emit, go to IDLE.
  - Otherwise go to WAIT_D2.
- WAIT_D2 + data byte: emit with d2 = byte, go to IDLE.
- Emit rules:
  - `CH_MESSAGE` = rs[7:4] and `CHAN` = rs[3:0], except 9 with d2 = 0 and `VEL0_IS_OFF` = 1 gives 4'h8.
  - `MSG_VALID` pulses only if `CHAN_MASK[rs[3:0]]` = 1. Output fields update only when `MSG_VALID` pulses.
- Timeout:
  - A counter clears on every non-real-time `RX_VALID` and increments in WAIT_D1/WAIT_D2.
  - When it reaches `TIMEOUT` (≠0): go to IDLE, pulse `ERR`, keep running status.
  - The counter saturates and is held at 0 in IDLE/SYSEX.

## Timing
- All outputs are registered. `MSG_VALID`/`RT_VALID`/`ERR` assert exactly 1 cycle after the `RX_VALID` cycle of the triggering byte, for 1 cycle.
- Back-to-back `RX_VALID` on consecutive cycles is supported with no lost bytes.
- Reset: state IDLE, running status invalid (`rs_reg` = 0), counter 0.
- Reset values of outputs: all strobes 0, `CH_MESSAGE`/`CHAN`/`DATA1`/`DATA2` = 0, `RT_BYTE` = 0.
- `RES` asserted mid-message discards the partial message. No strobe is issued in the reset cycle.
- `RES` and `RX_VALID` in the same cycle: reset wins and the byte is dropped.
- A timeout expiry in the same cycle as `RX_VALID` of a data byte: the byte wins and no `ERR` is raised.
- Latency from the final byte to `MSG_VALID` is 1 cycle, independent of message type.

## Test plan
- 90 3C 64 -> one `MSG_VALID`: `CH_MESSAGE` = 9, `CHAN` = 0, `DATA1` = 0x3C, `DATA2` = 0x64.
- 93 3C 64 3E 50 with `RUNNING_STATUS` = 1 -> two strobes, `CHAN` = 3: (0x3C, 0x64) then (0x3E, 0x50).
- 90 3C 00 with `VEL0_IS_OFF` = 1 -> `CH_MESSAGE` = 8, `DATA2` = 0. Then C5 07 -> `CH_MESSAGE` = C, `CHAN` = 5, `DATA1` = 7, `DATA2` = 0.
- 90 F8 3C FE 64 -> `RT_VALID` with F8 then FE. One Note On (0x3C, 0x64) with no `ERR`.
- `CHAN_MASK` = 16'h0001, stimulus 91 40 40 then 90 40 40 -> only the second message strobes.
- 90 3C, then silence for `TIMEOUT` cycles -> `ERR` pulse, state IDLE. A following 40 7F is parsed as running-status Note On (0x40, 0x7F). F0 01 02 F7 40 -> no message and no `ERR`.
